// File: rtl/reg_hazard_scoreboard.sv
// Hazard detection and forwarding-select unit: tracks in-flight writes, stalls on early load use.
// Optional macro RHS_PERF_CNT_EN adds saturating stall/forward performance counters.
module reg_hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NSRC   = 2,
  parameter int LAT    = 3,
  parameter int LD_RDY = 1,
  parameter int KILL   = 1,
  parameter int SW     = $clog2(LAT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_id_valid,
  input  logic [AW-1:0]        i_id_rd,
  input  logic                 i_id_we,
  input  logic                 i_id_ld,
  input  logic [NSRC*AW-1:0]   i_id_rs,
  input  logic [NSRC-1:0]      i_id_rs_used,
  input  logic                 i_flush,
  output logic                 o_id_stall,
  output logic [NSRC*SW-1:0]   o_ex_fwd_sel,
`ifdef RHS_PERF_CNT_EN
  output logic                 o_ex_valid,
  output logic [31:0]          o_perf_stall_cnt,
  output logic [31:0]          o_perf_fwd_cnt
`else
  output logic                 o_ex_valid
`endif
);

  // The WB slot never changes a decision (write-before-read register file),
  // so only the searchable slots 0..LAT-2 are stored.
  localparam int NK = LAT - 1;
  localparam int NS = (LAT > 1) ? LAT - 1 : 1;

  logic [NS-1:0] r_v;
  logic [NS-1:0] r_ld;
  logic [AW-1:0] r_rd [NS];
  logic [SW-1:0] r_fwd_sel [NSRC];
  logic          r_ex_valid;

  logic [NS-1:0]   w_live;
  logic [NSRC-1:0] w_src_stall;
  logic [SW-1:0]   w_sel [NSRC];
  logic            w_stall;
  logic            w_accept;
  logic            w_push;

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      w_live[k] = r_v[k] & ~(i_flush & (k < KILL));
    end
  end

  // Oldest-to-youngest scan so the youngest matching producer wins.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      w_sel[s]       = '0;
      w_src_stall[s] = 1'b0;
      if (i_id_rs_used[s] && (i_id_rs[s*AW +: AW] != '0)) begin
        for (int k = NK - 1; k >= 0; k--) begin
          if (w_live[k] && (r_rd[k] == i_id_rs[s*AW +: AW])) begin
            w_sel[s]       = SW'(k + 1);
            w_src_stall[s] = r_ld[k] && (k < LD_RDY);
          end
        end
      end
    end
  end

  assign w_stall    = i_id_valid & ~i_flush & ~reset & (|w_src_stall);
  assign w_accept   = i_id_valid & ~i_flush & ~w_stall;
  assign w_push     = w_accept & i_id_we & (i_id_rd != '0);
  assign o_id_stall = w_stall;
  assign o_ex_valid = r_ex_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v        <= '0;
      r_ld       <= '0;
      r_ex_valid <= 1'b0;
      for (int k = 0; k < NS; k++) begin
        r_rd[k] <= '0;
      end
    end else begin
      r_v[0]     <= w_push;
      r_ld[0]    <= w_push & i_id_ld;
      r_rd[0]    <= i_id_rd;
      r_ex_valid <= w_accept;
      for (int k = 1; k < NS; k++) begin
        r_v[k]  <= w_live[k-1];
        r_ld[k] <= r_ld[k-1];
        r_rd[k] <= r_rd[k-1];
      end
    end
  end

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_fwd
    always_ff @(posedge clk) begin
      if (reset) begin
        r_fwd_sel[gi] <= '0;
      end else begin
        r_fwd_sel[gi] <= w_accept ? w_sel[gi] : '0;
      end
    end
    assign o_ex_fwd_sel[gi*SW +: SW] = r_fwd_sel[gi];
  end

`ifdef RHS_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_fwd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_cnt <= '0;
      r_perf_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if ((|o_ex_fwd_sel) && (r_perf_fwd_cnt != 32'hFFFF_FFFF)) begin
        r_perf_fwd_cnt <= r_perf_fwd_cnt + 32'd1;
      end
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_fwd_cnt   = r_perf_fwd_cnt;
`endif

endmodule
